// File: rtl/sdram_arbit.sv
// sdram_arbit: central SDRAM bus scheduler. Holds the bus for the init
// sequencer until power-up completes, then grants it to refresh, write or
// read (refresh first, write/read alternated on a tie). Drives the granted
// sequencer's command/address/bank onto registered pins, with a watchdog
// that reclaims the bus from a sequencer that never signals completion.
module sdram_arbit #(
   parameter int TIMEOUT = 2047,
   parameter int TO_W    = 12
) (
   input  logic        sclk,
   input  logic        s_rst,
   input  logic        flag_init_end,
   input  logic [3:0]  init_cmd,
   input  logic [11:0] init_addr,
   input  logic        ref_req,
   input  logic        flag_ref_end,
   input  logic [3:0]  ref_cmd,
   input  logic        wr_req,
   input  logic        flag_wr_end,
   input  logic [3:0]  wr_cmd,
   input  logic [11:0] wr_addr,
   input  logic [1:0]  wr_bank,
   input  logic        rd_req,
   input  logic        flag_rd_end,
   input  logic [3:0]  rd_cmd,
   input  logic [11:0] rd_addr,
   input  logic [1:0]  rd_bank,
   output logic        ref_en,
   output logic        wr_en,
   output logic        rd_en,
   output logic [3:0]  sdram_cmd,
   output logic [11:0] sdram_addr,
   output logic [1:0]  sdram_bank,
   output logic [2:0]  grant,
   output logic        err_timeout
);

   localparam logic [3:0] CMD_NOP = 4'b0111;

   typedef enum logic [4:0] {
      S_INIT  = 5'b00001,
      S_ARBIT = 5'b00010,
      S_AREF  = 5'b00100,
      S_WRITE = 5'b01000,
      S_READ  = 5'b10000
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_last_wr;
   logic [TO_W-1:0] r_wdog;
   logic        r_ref_en, r_wr_en, r_rd_en, r_err;
   logic [3:0]  r_cmd;
   logic [11:0] r_addr;
   logic [1:0]  r_bank;
   logic        w_own, w_end, w_to;
   logic [3:0]  w_cmd;
   logic [11:0] w_addr;
   logic [1:0]  w_bank;

   // Next-state: arbitration in S_ARBIT, release on owner's end flag or watchdog
   always_comb begin
      w_next = r_state;
      w_own  = 1'b0;
      w_end  = 1'b0;
      w_to   = 1'b0;
      case (r_state)
         S_INIT:  if (flag_init_end) w_next = S_ARBIT;
         S_ARBIT: begin
            if (ref_req)                w_next = S_AREF;
            else if (wr_req && rd_req)  w_next = r_last_wr ? S_READ : S_WRITE;
            else if (wr_req)            w_next = S_WRITE;
            else if (rd_req)            w_next = S_READ;
         end
         S_AREF:  begin w_own = 1'b1; w_end = flag_ref_end; end
         S_WRITE: begin w_own = 1'b1; w_end = flag_wr_end;  end
         S_READ:  begin w_own = 1'b1; w_end = flag_rd_end;  end
         default: w_next = S_INIT;
      endcase
      // A coincident end flag wins over the watchdog, so no error is flagged.
      w_to = w_own && !w_end && (r_wdog == TO_W'(TIMEOUT - 1));
      if (w_own && (w_end || w_to)) w_next = S_ARBIT;
   end

   // Bus source select for the current owner; NOP when nobody owns the bus
   always_comb begin
      w_cmd  = CMD_NOP;
      w_addr = '0;
      w_bank = '0;
      case (r_state)
         S_INIT:  begin w_cmd = init_cmd; w_addr = init_addr; end
         S_AREF:  w_cmd = ref_cmd;
         S_WRITE: begin w_cmd = wr_cmd; w_addr = wr_addr; w_bank = wr_bank; end
         S_READ:  begin w_cmd = rd_cmd; w_addr = rd_addr; w_bank = rd_bank; end
         default: ;
      endcase
   end

   // State register and write/read alternation memory
   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         r_state   <= S_INIT;
         r_last_wr <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_ARBIT && w_next == S_WRITE) r_last_wr <= 1'b1;
         else if (r_state == S_ARBIT && w_next == S_READ) r_last_wr <= 1'b0;
      end
   end

   // One-cycle grant pulses on entry into an owner state
   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         r_ref_en <= 1'b0;
         r_wr_en  <= 1'b0;
         r_rd_en  <= 1'b0;
      end else begin
         r_ref_en <= (r_state == S_ARBIT) && (w_next == S_AREF);
         r_wr_en  <= (r_state == S_ARBIT) && (w_next == S_WRITE);
         r_rd_en  <= (r_state == S_ARBIT) && (w_next == S_READ);
      end
   end

   // Watchdog counter and sticky timeout flag
   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         r_wdog <= '0;
         r_err  <= 1'b0;
      end else begin
         if (w_next != r_state) r_wdog <= '0;
         else if (w_own)        r_wdog <= r_wdog + TO_W'(1);
         if (w_to) r_err <= 1'b1;
      end
   end

   // Registered pins: selected source appears one cycle after presentation
   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         r_cmd  <= CMD_NOP;
         r_addr <= '0;
         r_bank <= '0;
      end else begin
         r_cmd  <= w_cmd;
         r_addr <= w_addr;
         r_bank <= w_bank;
      end
   end

   assign ref_en      = r_ref_en;
   assign wr_en       = r_wr_en;
   assign rd_en       = r_rd_en;
   assign sdram_cmd   = r_cmd;
   assign sdram_addr  = r_addr;
   assign sdram_bank  = r_bank;
   assign grant       = r_state[4:2];
   assign err_timeout = r_err;

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

Central scheduler of the SDRAM controller: sits between the init, auto-refresh, write and read sequencers and the single SDRAM command/address bus. Holds the bus for the init sequencer until power-up completes. Then grants the bus to one sequencer at a time: refresh first, with write/read alternated when both request. Registers the granted sequencer's command, address and bank onto the pins, and includes a watchdog against a sequencer that never reports completion.

## Interface
- TIMEOUT, 2047: max cycles a grant may be held without an end flag before forced release
- TO_W, 12: width of watchdog counter (must hold TIMEOUT)
- sclk  in  1  system clock; all logic on rising edge
- s_rst  in  1  asynchronous, active-high reset
- flag_init_end  in  1  init sequence complete (level or pulse)
- init_cmd  in  4  {cs_n,ras_n,cas_n,we_n} from init sequencer
- init_addr  in  12  address from init sequencer
- ref_req  in  1  refresh request (level, held until granted)
- flag_ref_end  in  1  refresh done, 1-cycle pulse
- ref_cmd  in  4  refresh sequencer command
- wr_req  in  1  write request (level)
- flag_wr_end  in  1  write burst/session done, 1-cycle pulse
- wr_cmd  in  4 / wr_addr  in  12 / wr_bank  in  2  write sequencer bus
- rd_req  in  1  read request (level)
- flag_rd_end  in  1  read session done, 1-cycle pulse
- rd_cmd  in  4 / rd_addr  in  12 / rd_bank  in  2  read sequencer bus
- ref_en  out  1  refresh grant pulse
- wr_en  out  1  write grant pulse
- rd_en  out  1  read grant pulse
- sdram_cmd  out  4  registered command to pins
- sdram_addr  out  12  registered address to pins
- sdram_bank  out  2  registered bank to pins
- grant  out  3  one-hot {rd,wr,ref} current owner, 0 in INIT/ARBIT
- err_timeout  out  1  sticky watchdog flag

## Operation
- States: S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ (one-hot, 5 bits).
- S_INIT: bus sourced from init_cmd/init_addr, bank 0. When flag_init_end=1 → S_ARBIT. All *_req ignored.
- S_ARBIT: bus = NOP (4'b0111), addr 0, bank 0. Priority:
  - ref_req → S_AREF.
  - Else wr_req and rd_req: grant the one not granted last (last_wr bit; reset value 0, so write wins the first tie).
  - Else wr_req → S_WRITE; else rd_req → S_READ; else stay.
- Grant pulse: ref_en/wr_en/rd_en high exactly one cycle, the cycle state enters the granted state. At most one high at any time.
- last_wr updates on entry to S_WRITE (1) or S_READ (0); unchanged by refresh.
- S_AREF: bus = ref_cmd, addr 0, bank 0; flag_ref_end → S_ARBIT.
- S_WRITE: bus = wr_cmd/wr_addr/wr_bank; flag_wr_end → S_ARBIT.
- S_READ: bus = rd_cmd/rd_addr/rd_bank; flag_rd_end → S_ARBIT.
- End flags from a non-owning sequencer are ignored.
- Refresh pre-emption of a running write/read is handled by that sequencer (it sees ref_req directly and ends early). The arbiter only re-arbitrates on the end flag, and refresh then wins.
- Watchdog: counter clears on every state change. It increments each cycle in S_AREF/S_WRITE/S_READ. On reaching TIMEOUT with no end flag: → S_ARBIT and err_timeout ← 1. err_timeout clears only on s_rst.
- End flag and timeout in the same cycle: treated as a normal end, err_timeout not set.

## Timing
- Reset values: state S_INIT, sdram_cmd 4'b0111, sdram_addr 0, sdram_bank 0, ref_en/wr_en/rd_en 0, grant 0, err_timeout 0, last_wr 0, watchdog 0.
- Bus outputs registered: pins show the selected source's value one sclk after it is presented. Sequencers' cmd/addr must therefore be co-timed.
- Request → grant pulse: request sampled high in S_ARBIT at edge N; the *_en pulse and new state appear after edge N.
- End flag at edge N → S_ARBIT after edge N. Earliest next grant is after edge N+1, giving at least one NOP cycle between owners.
- Reset asserted mid-grant: all outputs return to reset values immediately (async). The arbiter restarts in S_INIT and waits for a new flag_init_end.

## Test plan
- Reset then flag_init_end pulse while wr_req=1: init_cmd 4'b0010 appears on sdram_cmd the cycle after presentation. wr_en stays 0 until S_ARBIT, then rises after ARBIT, one cycle wide.
- ref_req, wr_req and rd_req all asserted in S_ARBIT: ref_en pulses first. After flag_ref_end, wr_en pulses. After flag_wr_end with rd_req and wr_req still high, rd_en pulses (alternation).
- In S_READ, drive flag_wr_end: ignored, state stays S_READ. Then flag_rd_end: exactly one NOP cycle on sdram_cmd before the next grant.
- In S_WRITE with wr_cmd=4'b0100, wr_addr=12'h0A5, wr_bank=2'b01: pins show 4'b0100/12'h0A5/2'b01 one cycle later. In S_ARBIT pins show 4'b0111/0/0.
- TIMEOUT=8, grant write, never pulse flag_wr_end: after 8 cycles return to S_ARBIT and err_timeout=1, held through later grants. A case with flag_wr_end coincident with the 8th cycle leaves err_timeout=0.
- Assert s_rst mid-S_WRITE: sdram_cmd=4'b0111, grant=0 immediately. After release, the arbiter stays in S_INIT until flag_init_end.
